mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, SRAM access cycles per transaction (legal 1..15).
REQ-002 SHALL have port Clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-004 SHALL have ports cpu_req / dbg_req  input  1  each requester's transaction request, held high until its ack.
REQ-005 SHALL have ports cpu_we / dbg_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports cpu_addr / dbg_addr  input  20  word address.
REQ-007 SHALL have ports cpu_wdata / dbg_wdata  input  16  write data.
REQ-008 SHALL have ports cpu_rdata / dbg_rdata  output  16  registered read data.
REQ-009 SHALL have ports cpu_ack / dbg_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have port ADDR  output  20  SRAM address.
REQ-011 SHALL have ports Data_to_SRAM  output  16  and Data_from_SRAM  input  16  split SRAM data bus.
REQ-012 SHALL have port data_oe  output  1  tristate enable for Data_to_SRAM, 1 = drive.
REQ-013 SHALL have ports Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB  output  1 each  active-low SRAM strobes.

Function
REQ-014 SHALL implement Moore FSM with states IDLE, ACCESS, DONE; all SRAM strobes decoded from registered state/grant only.
REQ-015 IDLE: if any req high, SHALL grant one requester, latch its we/addr/wdata into internal registers, load wait counter with WAIT_CYCLES-1, go ACCESS; else stay IDLE.
REQ-016 Arbitration with both requests high SHALL grant cpu (fixed priority) unless MEM_ARB_ROUND_ROBIN_EN is defined.
REQ-017 ACCESS: Mem_CE=Mem_UB=Mem_LB=0, ADDR=latched address; read drives Mem_OE=0, Mem_WE=1, data_oe=0; write drives Mem_OE=1, Mem_WE=0, data_oe=1, Data_to_SRAM=latched wdata.
REQ-018 ACCESS SHALL last exactly WAIT_CYCLES cycles (counter decrements to 0, then DONE).
REQ-019 On final ACCESS cycle of a read, SHALL capture Data_from_SRAM into granted requester's rdata; other requester's rdata unchanged.
REQ-020 DONE: all strobes inactive (1), data_oe=0, granted ack=1 for exactly this cycle, next state IDLE unconditionally.
REQ-021 Latency: ack asserted WAIT_CYCLES+1 cycles after the IDLE cycle in which req was sampled (3 cycles for default).
REQ-022 Requester SHALL drop req in the cycle following its ack; req still high in IDLE after DONE starts a new transaction (back-to-back legal, 1 idle cycle between accesses).
REQ-023 Input changes on the granted port during ACCESS SHALL have no effect (latched values used).
REQ-024 Non-granted requester SHALL wait with no ack; its request is never dropped by the arbiter.
REQ-025 Outside ACCESS: Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB = 1, data_oe = 0, ADDR holds last latched value.

Reset
REQ-026 Reset SHALL force state IDLE, counter 0, grant cpu, round-robin pointer to favour cpu, latched addr/wdata 0, cpu_rdata=dbg_rdata=0, acks 0.
REQ-027 Reset during ACCESS SHALL abort the transaction: strobes inactive from the following cycle, no ack issued, no rdata update.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant SHALL go to the port not granted last; pointer updates at every grant.
REQ-029 Macro MEM_ARB_ROUND_ROBIN_EN undefined: cpu SHALL always win simultaneous requests; dbg served only when cpu_req low in IDLE.

Verification
REQ-030 Reset, cpu read addr 0x00010, SRAM model returns 0x3A5C -> Mem_OE low 2 cycles, cpu_ack pulse 3 cycles after request, cpu_rdata=0x3A5C.
REQ-031 dbg write addr 0xFFFFF data 0xBEEF -> Mem_WE low 2 cycles, data_oe high same 2 cycles, Data_to_SRAM=0xBEEF, dbg_ack one pulse, model holds 0xBEEF at 0xFFFFF.
REQ-032 cpu and dbg requesting every cycle for 4 transactions -> without macro: 4 cpu acks, 0 dbg acks; with macro: acks alternate cpu,dbg,cpu,dbg.
REQ-033 Reset asserted in 1st ACCESS cycle of cpu write -> Mem_WE=1 next cycle, no cpu_ack, state IDLE, cpu_rdata=0.
REQ-034 WAIT_CYCLES=1, cpu read held high back-to-back -> acks every 3 cycles, strobes inactive in each DONE and IDLE cycle.
REQ-035 cpu_addr changed 0x00010->0x00020 mid-ACCESS -> ADDR stays 0x00010 until DONE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port (cpu, dbg) arbiter in front of an asynchronous
// 16-bit SRAM with split data bus.
//
// Each requester raises *_req with we/addr/wdata and holds it until its
// one-cycle *_ack.  The winner's command is latched in IDLE.  The FSM then
// spends WAIT_CYCLES cycles in ACCESS driving the SRAM strobes, and one cycle
// in DONE pulsing the ack.  Read data is captured on the last ACCESS cycle.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
// on simultaneous requests.  When it is undefined, cpu has fixed priority.
//
// Ports
//   Clk, Reset                  clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       cpu command inputs
//   dbg_req/we/addr/wdata       dbg command inputs
//   cpu_rdata, dbg_rdata        registered read data per requester
//   cpu_ack, dbg_ack            one-cycle completion pulses
//   ADDR                        SRAM address (holds last latched value)
//   Data_to_SRAM, data_oe       write data and its tristate enable (1 = drive)
//   Data_from_SRAM              read data from SRAM
//   Mem_CE/OE/WE/UB/LB          active-low SRAM strobes
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winning command
// ACCESS | SRAM strobes active for WAIT_CYCLES cycles
// DONE   | strobes released, ack pulsed to the granted requester

module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [19:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] cpu_rdata,
  output logic [15:0] dbg_rdata,
  output logic        cpu_ack,
  output logic        dbg_ack,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        data_oe,
  output logic        Mem_CE,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic        Mem_UB,
  output logic        Mem_LB
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;   // 0 = cpu, 1 = dbg
  logic        we_q;
  logic [19:0] addr_q;
  logic [15:0] wdata_q;
  logic        pick;               // requester that would win this cycle
  logic        start;              // IDLE -> ACCESS this cycle
  logic        capture;            // last ACCESS cycle of a read
  logic        in_access;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic        last_q;             // port granted most recently; 1 after reset so cpu wins first

  always_comb begin
    pick = 1'b0;
    if (cpu_req && dbg_req) pick = ~last_q;
    else                    pick = ~cpu_req;
  end

  always_ff @(posedge Clk) begin
    if (Reset)      last_q <= 1'b1;
    else if (start) last_q <= pick;
  end
`else
  // Fixed priority: dbg only wins when cpu is not asking.
  always_comb begin
    pick = ~cpu_req;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    start   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          start   = 1'b1;
          grant_d = pick;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          capture = ~we_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  // Command latch: the granted port's inputs are ignored once ACCESS starts.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      we_q    <= 1'b0;
      addr_q  <= 20'd0;
      wdata_q <= 16'd0;
    end else if (start) begin
      we_q    <= pick ? dbg_we    : cpu_we;
      addr_q  <= pick ? dbg_addr  : cpu_addr;
      wdata_q <= pick ? dbg_wdata : cpu_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cpu_rdata <= 16'd0;
      dbg_rdata <= 16'd0;
    end else if (capture) begin
      if (grant_q) dbg_rdata <= Data_from_SRAM;
      else         cpu_rdata <= Data_from_SRAM;
    end
  end

  // All SRAM-facing outputs decode from registered state only.
  assign in_access    = (state_q == ACCESS);
  assign Mem_CE       = ~in_access;
  assign Mem_UB       = ~in_access;
  assign Mem_LB       = ~in_access;
  assign Mem_OE       = ~(in_access & ~we_q);
  assign Mem_WE       = ~(in_access & we_q);
  assign data_oe      = in_access & we_q;
  assign ADDR         = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign cpu_ack      = (state_q == DONE) & ~grant_q;
  assign dbg_ack      = (state_q == DONE) & grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [19:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        cpu_ack, dbg_ack;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] sram_dout;
  logic        data_oe, Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB;

  // second instance with WAIT_CYCLES=1
  logic        w1_cpu_req, w1_cpu_we, w1_dbg_req, w1_dbg_we;
  logic [19:0] w1_cpu_addr, w1_dbg_addr;
  logic [15:0] w1_cpu_wdata, w1_dbg_wdata;
  logic [15:0] w1_cpu_rdata, w1_dbg_rdata;
  logic        w1_cpu_ack, w1_dbg_ack;
  logic [19:0] w1_ADDR;
  logic [15:0] w1_Data_to_SRAM;
  logic [15:0] w1_sram_dout;
  logic        w1_data_oe, w1_Mem_CE, w1_Mem_OE, w1_Mem_WE, w1_Mem_UB, w1_Mem_LB;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [bit [19:0]];

  always #5 Clk = ~Clk;

  mem_arbiter #(.WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .cpu_rdata(cpu_rdata), .dbg_rdata(dbg_rdata), .cpu_ack(cpu_ack), .dbg_ack(dbg_ack),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(sram_dout),
    .data_oe(data_oe), .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Mem_UB(Mem_UB), .Mem_LB(Mem_LB)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(w1_cpu_req), .cpu_we(w1_cpu_we), .cpu_addr(w1_cpu_addr), .cpu_wdata(w1_cpu_wdata),
    .dbg_req(w1_dbg_req), .dbg_we(w1_dbg_we), .dbg_addr(w1_dbg_addr), .dbg_wdata(w1_dbg_wdata),
    .cpu_rdata(w1_cpu_rdata), .dbg_rdata(w1_dbg_rdata), .cpu_ack(w1_cpu_ack), .dbg_ack(w1_dbg_ack),
    .ADDR(w1_ADDR), .Data_to_SRAM(w1_Data_to_SRAM), .Data_from_SRAM(w1_sram_dout),
    .data_oe(w1_data_oe), .Mem_CE(w1_Mem_CE), .Mem_OE(w1_Mem_OE), .Mem_WE(w1_Mem_WE),
    .Mem_UB(w1_Mem_UB), .Mem_LB(w1_Mem_LB)
  );

  // Asynchronous SRAM model, evaluated mid-cycle when outputs are stable.
  always @(negedge Clk) begin
    if (!Mem_CE && !Mem_WE) mem[ADDR] = Data_to_SRAM;
    sram_dout = mem.exists(ADDR) ? mem[ADDR] : 16'h0000;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    w1_cpu_req = 0; w1_cpu_we = 0; w1_cpu_addr = 0; w1_cpu_wdata = 0;
    w1_dbg_req = 0; w1_dbg_we = 0; w1_dbg_addr = 0; w1_dbg_wdata = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    Reset = 1;
    tick();
    tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB} !== 5'b11111) begin
      failures++; $display("FAIL reset_strobes got=%b exp=11111", {Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB});
    end
    checks++;
    if ({data_oe, cpu_ack, dbg_ack} !== 3'b000) begin
      failures++; $display("FAIL reset_oe_acks got=%b exp=000", {data_oe, cpu_ack, dbg_ack});
    end
    checks++;
    if ({cpu_rdata, dbg_rdata} !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=00000000", {cpu_rdata, dbg_rdata});
    end
    checks++;
    if (ADDR !== 20'h0 || Data_to_SRAM !== 16'h0) begin
      failures++; $display("FAIL reset_addr_data got=%h/%h exp=00000/0000", ADDR, Data_to_SRAM);
    end
  endtask

  task automatic test_cpu_read();
    int oe_low = 0, acks = 0, ack_cyc = 0, ce_bad = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (Mem_OE === 1'b0) oe_low++;
      if (dbg_ack === 1'b1) ce_bad++;
      if (cpu_ack === 1'b1) begin
        acks++;
        if (ack_cyc == 0) ack_cyc = c;
        if (Mem_CE !== 1'b1 || Mem_OE !== 1'b1) ce_bad++;
        cpu_req = 0;
      end
    end
    checks++;
    if (oe_low != 2) begin failures++; $display("FAIL read_oe_cycles got=%0d exp=2", oe_low); end
    checks++;
    if (ack_cyc != 3) begin failures++; $display("FAIL read_ack_latency got=%0d exp=3", ack_cyc); end
    checks++;
    if (acks != 1) begin failures++; $display("FAIL read_ack_count got=%0d exp=1", acks); end
    checks++;
    if (ce_bad != 0) begin failures++; $display("FAIL read_done_strobes got=%0d bad exp=0", ce_bad); end
    checks++;
    if (cpu_rdata !== 16'h3A5C || dbg_rdata !== 16'h0000) begin
      failures++; $display("FAIL read_rdata got=%h/%h exp=3a5c/0000", cpu_rdata, dbg_rdata);
    end
  endtask

  task automatic test_dbg_write();
    int we_low = 0, oe_match = 0, data_bad = 0, dacks = 0, cacks = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 20'hFFFFF; dbg_wdata = 16'hBEEF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (Mem_WE === 1'b0) we_low++;
      if (data_oe === 1'b1 && Mem_WE === 1'b0) oe_match++;
      if (data_oe !== ~Mem_WE) data_bad++;
      if (data_oe === 1'b1 && Data_to_SRAM !== 16'hBEEF) data_bad++;
      if (cpu_ack === 1'b1) cacks++;
      if (dbg_ack === 1'b1) begin dacks++; dbg_req = 0; end
    end
    checks++;
    if (we_low != 2) begin failures++; $display("FAIL write_we_cycles got=%0d exp=2", we_low); end
    checks++;
    if (oe_match != 2 || data_bad != 0) begin
      failures++; $display("FAIL write_data_oe got=%0d/%0d exp=2/0", oe_match, data_bad);
    end
    checks++;
    if (dacks != 1 || cacks != 0) begin
      failures++; $display("FAIL write_acks got=%0d/%0d exp=1/0", dacks, cacks);
    end
    checks++;
    if (!mem.exists(20'hFFFFF) || mem[20'hFFFFF] !== 16'hBEEF) begin
      failures++; $display("FAIL write_mem got=%h exp=beef", mem.exists(20'hFFFFF) ? mem[20'hFFFFF] : 16'hxxxx);
    end
    checks++;
    if (ADDR !== 20'hFFFFF) begin failures++; $display("FAIL write_addr_hold got=%h exp=fffff", ADDR); end
  endtask

  task automatic test_arbitration();
    int n = 0, ncpu = 0, ndbg = 0, both = 0;
    int ack_at [4];
    logic [3:0] seq = 4'b0000;
    logic [3:0] exp_seq;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    apply_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    dbg_req = 1; dbg_we = 0; dbg_addr = 20'h00030;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (cpu_ack === 1'b1 && dbg_ack === 1'b1) both++;
      if ((cpu_ack === 1'b1 || dbg_ack === 1'b1) && n < 4) begin
        seq[n] = dbg_ack;
        ack_at[n] = c;
        n++;
      end
      if (cpu_ack === 1'b1) ncpu++;
      if (dbg_ack === 1'b1) ndbg++;
    end
    cpu_req = 0; dbg_req = 0;
    tick(); tick();
    checks++;
    if (n != 4 || both != 0) begin failures++; $display("FAIL arb_ack_total got=%0d both=%0d exp=4 both=0", n, both); end
    checks++;
    if (seq !== exp_seq) begin failures++; $display("FAIL arb_sequence got=%b exp=%b", seq, exp_seq); end
`ifndef MEM_ARB_ROUND_ROBIN_EN
    checks++;
    if (ncpu != 4 || ndbg != 0) begin failures++; $display("FAIL arb_fixed_counts got=%0d/%0d exp=4/0", ncpu, ndbg); end
`else
    checks++;
    if (ncpu != 2 || ndbg != 2) begin failures++; $display("FAIL arb_rr_counts got=%0d/%0d exp=2/2", ncpu, ndbg); end
`endif
    checks++;
    if (n == 4 && (ack_at[0] != 3 || ack_at[1] != 7 || ack_at[2] != 11 || ack_at[3] != 15)) begin
      failures++; $display("FAIL arb_ack_cycles got=%0d,%0d,%0d,%0d exp=3,7,11,15", ack_at[0], ack_at[1], ack_at[2], ack_at[3]);
    end
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00020; cpu_wdata = 16'h1234;
    tick();
    checks++;
    if (Mem_WE !== 1'b0) begin failures++; $display("FAIL abort_we_active got=%b exp=0", Mem_WE); end
    Reset = 1; cpu_req = 0;
    tick();
    Reset = 0;
    checks++;
    if (Mem_WE !== 1'b1 || Mem_CE !== 1'b1 || data_oe !== 1'b0) begin
      failures++; $display("FAIL abort_strobes got=%b%b%b exp=110", Mem_WE, Mem_CE, data_oe);
    end
    for (int c = 0; c < 5; c++) begin
      if (cpu_ack === 1'b1 || Mem_CE === 1'b0) acks++;
      tick();
    end
    checks++;
    if (acks != 0) begin failures++; $display("FAIL abort_no_ack got=%0d exp=0", acks); end
    checks++;
    if (cpu_rdata !== 16'h0 || ADDR !== 20'h0) begin
      failures++; $display("FAIL abort_cleared got=%h/%h exp=0000/00000", cpu_rdata, ADDR);
    end
  endtask

  task automatic test_addr_latched();
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    tick();
    checks++;
    if (ADDR !== 20'h00010 || Mem_OE !== 1'b0) begin
      failures++; $display("FAIL latch_first got=%h oe=%b exp=00010 oe=0", ADDR, Mem_OE);
    end
    cpu_addr = 20'h00020; cpu_we = 1; cpu_wdata = 16'hDEAD;
    tick();
    checks++;
    if (ADDR !== 20'h00010 || Mem_WE !== 1'b1 || data_oe !== 1'b0) begin
      failures++; $display("FAIL latch_mid got=%h we=%b oe=%b exp=00010 we=1 oe=0", ADDR, Mem_WE, data_oe);
    end
    tick();
    cpu_req = 0;
    checks++;
    if (ADDR !== 20'h00010 || cpu_ack !== 1'b1 || cpu_rdata !== 16'h3A5C) begin
      failures++; $display("FAIL latch_done got=%h ack=%b rd=%h exp=00010 ack=1 rd=3a5c", ADDR, cpu_ack, cpu_rdata);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back_w1();
    int n = 0, oe_low = 0, bad = 0, gap_bad = 0, last = 0, first = 0;
    logic prev_ack = 1'b0;
    apply_reset();
    w1_sram_dout = 16'h5A5A;
    w1_cpu_req = 1; w1_cpu_we = 0; w1_cpu_addr = 20'h00040;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (w1_Mem_OE === 1'b0) oe_low++;
      if ((w1_cpu_ack === 1'b1 || prev_ack) &&
          {w1_Mem_CE, w1_Mem_OE, w1_Mem_WE, w1_Mem_UB, w1_Mem_LB, w1_data_oe} !== 6'b111110) bad++;
      if (w1_cpu_ack === 1'b1) begin
        if (n == 0) first = c;
        else if (c - last != 3) gap_bad++;
        last = c;
        n++;
      end
      prev_ack = w1_cpu_ack;
    end
    w1_cpu_req = 0;
    tick(); tick();
    checks++;
    if (n != 4 || first != 2) begin failures++; $display("FAIL b2b_acks got=%0d first=%0d exp=4 first=2", n, first); end
    checks++;
    if (gap_bad != 0) begin failures++; $display("FAIL b2b_spacing got=%0d bad gaps exp=0", gap_bad); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL b2b_idle_strobes got=%0d bad exp=0", bad); end
    checks++;
    if (oe_low != 4) begin failures++; $display("FAIL b2b_oe_cycles got=%0d exp=4", oe_low); end
    checks++;
    if (w1_cpu_rdata !== 16'h5A5A || w1_dbg_rdata !== 16'h0000) begin
      failures++; $display("FAIL b2b_rdata got=%h/%h exp=5a5a/0000", w1_cpu_rdata, w1_dbg_rdata);
    end
  endtask

  initial begin
    Reset = 1;
    w1_sram_dout = 16'h0000;
    mem[20'h00010] = 16'h3A5C;
    mem[20'h00030] = 16'h7777;
    idle_inputs();
    test_reset();
    test_cpu_read();
    test_dbg_write();
    test_arbitration();
    test_reset_abort();
    test_addr_latched();
    test_back_to_back_w1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
